// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed 7-segment scan controller with staged/shadow registers.
// Staging is committed to shadow at frame wrap so a frame never shows a torn value.
module seg7_scan_ctrl #(
  parameter int DWELL_CYC = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        wr_en,
  input  logic        wr_addr,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        frame_tick
);

  localparam int MAXC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYC - 1);
  localparam logic [CW-1:0] BLANK_LAST =
    CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);

  typedef enum logic {
    ST_BLANK,
    ST_SHOW
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  digit_q, digit_d;
  logic [CW-1:0] count_q, count_d;

  logic [31:0] val_stg_q, val_stg_d;
  logic [15:0] ctl_stg_q, ctl_stg_d;
  logic [31:0] val_sh_q, val_sh_d;
  logic [15:0] ctl_sh_q, ctl_sh_d;

  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;
  logic [7:0]  an_q, an_d;
  logic        tick_q, tick_d;

  logic        wrap;
  logic        commit;

  function automatic logic [6:0] hex2seg(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  assign rd_data = wr_addr ? {16'h0000, ctl_stg_q} : val_stg_q;

  always_comb begin
    val_stg_d = val_stg_q;
    ctl_stg_d = ctl_stg_q;
    for (int b = 0; b < 4; b++) begin
      if (wr_en && !wr_addr && wr_be[b])
        val_stg_d[8*b +: 8] = wr_data[8*b +: 8];
    end
    for (int b = 0; b < 2; b++) begin
      if (wr_en && wr_addr && wr_be[b])
        ctl_stg_d[8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    digit_d = digit_q;
    count_d = count_q + CW'(1);
    wrap    = 1'b0;
    if (!en) begin
      state_d = ST_BLANK;
      digit_d = 3'd0;
      count_d = '0;
    end else begin
      unique case (state_q)
        ST_BLANK: begin
          if (BLANK_CYC == 0 || count_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            count_d = '0;
          end
        end
        default: begin
          if (count_q == DWELL_LAST) begin
            count_d = '0;
            digit_d = digit_q + 3'd1;
            state_d = (BLANK_CYC == 0) ? ST_SHOW : ST_BLANK;
            wrap    = (digit_q == 3'd7);
          end
        end
      endcase
    end
  end

  // Commit uses the pre-write staging value; a same-cycle write waits a frame.
  assign commit = !en || wrap;

  always_comb begin
    val_sh_d = commit ? val_stg_q : val_sh_q;
    ctl_sh_d = commit ? ctl_stg_q : ctl_sh_q;
  end

  // Outputs are decoded from next state so they move on the FSM's own edge.
  always_comb begin
    an_d   = 8'hFF;
    seg_d  = 7'h7F;
    dp_d   = 1'b1;
    tick_d = wrap;
    if (state_d == ST_SHOW) begin
      an_d[digit_d] = ~ctl_sh_d[{1'b0, digit_d}];
      seg_d = hex2seg(val_sh_d[{digit_d, 2'b00} +: 4]);
      dp_d  = ~ctl_sh_d[{1'b1, digit_d}];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_BLANK;
      digit_q   <= 3'd0;
      count_q   <= '0;
      val_stg_q <= 32'h0;
      ctl_stg_q <= 16'h00FF;
      val_sh_q  <= 32'h0;
      ctl_sh_q  <= 16'h00FF;
      an_q      <= 8'hFF;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
      tick_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      digit_q   <= digit_d;
      count_q   <= count_d;
      val_stg_q <= val_stg_d;
      ctl_stg_q <= ctl_stg_d;
      val_sh_q  <= val_sh_d;
      ctl_sh_q  <= ctl_sh_d;
      an_q      <= an_d;
      seg_q     <= seg_d;
      dp_q      <= dp_d;
      tick_q    <= tick_d;
    end
  end

  assign an_n       = an_q;
  assign seg_n      = seg_q;
  assign dp_n       = dp_q;
  assign frame_tick = tick_q;

endmodule
